// File: rtl/camera_pkg.sv
// camera_pkg: shared clocking constants and helpers for the camera interface blocks
package camera_pkg;

    localparam int SYS_CLK_HZ  = 50_000_000;
    localparam int CAM_CLK_DIV = 2;

    // Cycles the divided clock spends high per period; odd ratios round the high phase down.
    function automatic int div_high_cycles(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/clock_divider.sv
// clock_divider: integer divider producing a registered, glitch-free p_clock in the clk domain
module clock_divider
    import camera_pkg::*;
#(
    parameter int DIV = CAM_CLK_DIV
) (
    input  logic clk,
    output logic p_clock,
    input  logic rst
);

    localparam int CNT_W    = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int HIGH_CYC = div_high_cycles(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("clock_divider: DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt;

    // Phase counter wraps at DIV-1; p_clock is high for the first HIGH_CYC phases of each period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            p_clock <= 1'b0;
        end else begin
            p_clock <= cnt < CNT_W'(HIGH_CYC);
            cnt     <= (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: directed checks of DIV=2/4/5 dividers against a period/duty model
module tb_clock_divider;

    logic clk = 1'b0;
    logic r2 = 1'b1, r4 = 1'b1, r5 = 1'b1;
    logic p2, p4, p5;
    int checks = 0;
    int errors = 0;

    // Edges since reset release per instance: -2 never reset, -1 in reset.
    int n2 = -2, n4 = -2, n5 = -2;

    always #10 clk = ~clk;

    clock_divider #(.DIV(2)) d2 (.clk(clk), .p_clock(p2), .rst(r2));
    clock_divider #(.DIV(4)) d4 (.clk(clk), .p_clock(p4), .rst(r4));
    clock_divider #(.DIV(5)) d5 (.clk(clk), .p_clock(p5), .rst(r5));

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Period/duty rule: phase k of a period is high when k < floor(DIV/2).
    function automatic int model_p(input int n, input int div);
        return (n < 0) ? 0 : (((n % div) < (div / 2)) ? 1 : 0);
    endfunction

    // Model advances on each clk rising edge from the sampled reset.
    always @(posedge clk) begin
        n2 = r2 ? -1 : (n2 == -2 ? -2 : n2 + 1);
        n4 = r4 ? -1 : (n4 == -2 ? -2 : n4 + 1);
        n5 = r5 ? -1 : (n5 == -2 ? -2 : n5 + 1);
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (n2 != -2) chk("model_p2", int'(p2), model_p(n2, 2));
        if (n4 != -2) chk("model_p4", int'(p4), model_p(n4, 4));
        if (n5 != -2) chk("model_p5", int'(p5), model_p(n5, 5));
        if (n4 >= 0) chk("model_cnt4", int'(d4.cnt), (n4 + 1) % 4);
        if (n5 != -2) chk("cnt5_below_div", int'(d5.cnt < 3'd5), 1);
    end

    logic s2[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic s4[10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    logic s5[10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};

    initial begin
        int rises;
        logic prev;
        bit found;
        repeat (10) begin
            @(negedge clk);
            chk("held_reset_p2", int'(p2), 0);
        end
        r2 = 1'b0; r4 = 1'b0; r5 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("seq_div2", int'(p2), int'(s2[k]));
            chk("seq_div4", int'(p4), int'(s4[k]));
            chk("seq_div5", int'(p5), int'(s5[k]));
        end
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            found = (p4 == 1'b1);
        end
        chk("find_high_div4", int'(found), 1);
        r4 = 1'b1;
        @(negedge clk);
        chk("midreset_p4", int'(p4), 0);
        chk("midreset_cnt4", int'(d4.cnt), 0);
        r4 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("restart_div4", int'(p4), int'(s4[k]));
        end
        rises = 0;
        prev = p2;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (p2 && !prev) rises++;
            prev = p2;
        end
        chk("rises_div2", rises, 500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Integer clock divider for the camera interface. It derives a slower pixel/peripheral clock (`p_clock`) from the system clock `clk`.
- Default use: 50 MHz system clock (20 ns period) divided by 2, giving 25 MHz for the camera XCLK/pixel domain.
- `p_clock` is a registered, glitch-free output in the `clk` domain. Downstream logic may use it as a clock or sample it as an enable.

Parameters:
- DIV, 2, division ratio: `p_clock` period = DIV `clk` cycles; legal range 2..65535.
- CNT_W, $clog2(DIV), counter width; derived localparam, not overridable.
- HIGH_CYC, DIV/2 (integer floor), number of `clk` cycles `p_clock` is high per period; derived localparam.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- p_clock  output  1  divided clock, registered.
- rst  input  1  synchronous, active-high reset.
- Positional order at instantiation is (clk, p_clock, rst).

Behaviour:
- Single clock domain. No combinational path from any input to `p_clock`.
- Reset: synchronous, active-high. On any `clk` rising edge with `rst`=1: `cnt` <= 0 and `p_clock` <= 0. While `rst` is held, `p_clock` stays 0.
- Normal operation, each rising edge with `rst`=0:
  - `p_clock` <= (`cnt` < HIGH_CYC), where `cnt` is the value before the update.
  - `cnt` <= (`cnt` == DIV-1) ? 0 : `cnt`+1.
- Latency: the first `clk` edge with `rst`=0 drives `p_clock` to 1. The first rising edge of `p_clock` is therefore one register delay after reset deasserts.
- Waveform, repeating with period DIV:
  - HIGH_CYC cycles high, then DIV-HIGH_CYC cycles low.
  - Even DIV gives exactly 50% duty.
  - Odd DIV gives high for floor(DIV/2) cycles and low for ceil(DIV/2) cycles.
- DIV=2: `p_clock` toggles on every `clk` edge, giving a `clk`/2 square wave.
- Wrap-around: `cnt` returns to 0 after DIV-1. It never exceeds DIV-1, even when DIV is not a power of two.
- Reset mid-period: takes effect on the next edge regardless of phase. `cnt` and `p_clock` restart from 0 and the sequence is identical to power-up.
- Reset deasserted while `p_clock` is high: not possible, because reset forces it low.
- Parameter check: an elaboration-time assertion/$error when DIV < 2.
- Simulation with no reset ever applied: `p_clock` may be X. The `cnt` register carries no initial-value reliance; reset is mandatory.

Decomposition:
- Shared package (camera_pkg): `SYS_CLK_HZ`=50_000_000, `CAM_CLK_DIV`=2, and a function `div_high_cycles(div)`. The package is reused by the camera capture blocks.
- No sub-module. A single flat module containing the counter and the output register.

Test Plan:
- DIV=2, `clk` period 20 ns, `rst`=1 for 2 edges then 0 → `p_clock`=0 during reset; after release it reads 1,0,1,0 on successive edges (40 ns period, 50% duty).
- DIV=2, `rst` held high for 10 edges → `p_clock` stays constant 0 throughout.
- DIV=4 → after release the sequence is 1,1,0,0 repeating; `cnt` sequence is 0,1,2,3,0.
- DIV=5 (odd) → `p_clock` sequence is 1,1,0,0,0 repeating; `cnt` never reaches 5 (wrap check).
- DIV=4, `rst` pulsed for one edge while `p_clock`=1 (mid-high phase) → next edge `p_clock`=0 and `cnt`=0; afterwards the sequence restarts 1,1,0,0 exactly as from power-up.
- DIV=2, run 1000 edges against a reference model → zero mismatches; edge count on `p_clock` equals `clk` edges/2.
